pc_gen: RTL and testbench
=========================

# pc_gen

Fetch-stage program-counter generator for the pipelined MIPS core; the registered successor to the combinational next-PC calculator. It owns the PC register and selects the next fetch address from reset, exception entry, `eret` return, branch, `j`/`jal` and `jr`/`jalr` redirects. It adds a one-entry redirect buffer so that a redirect resolved in D during a fetch-side stall is not lost. It also flags fetch address errors (AdEL) against a parametrised instruction-memory window.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset.
- `EXC_PC`, 32'h0000_4180, exception handler entry address.
- `IM_BASE`, 32'h0000_3000, first legal fetch address.
- `IM_WORDS`, 4096, instruction-memory depth in words; legal range is `IM_BASE` to `IM_BASE+4*IM_WORDS-1`.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `f_stall` in 1: fetch-side stall (IM wait or pipeline freeze); PC holds.
- `pc_d` in 32: PC of the instruction currently in D.
- `br_taken` in 1: branch in D resolved taken.
- `br_off` in 32: sign-extended 16-bit branch offset, in words.
- `j_en` in 1: `j`/`jal` in D.
- `imm26` in 26: jump index field.
- `jr_en` in 1: `jr`/`jalr` in D.
- `jr_target` in 32: forwarded rs value.
- `exc_req` in 1: exception or interrupt taken this cycle.
- `eret_req` in 1: `eret` committing this cycle.
- `epc` in 32: return address for `eret`.
- `pc` out 32: current fetch address (register output).
- `fetch_adel` out 1: `pc` is misaligned or outside the IM window.
- `redir_pending` out 1: redirect buffer occupied.

## Operation
- Live redirect target, computed combinationally, uses `pd4 = pc_d + 4`:
  - Priority `j_en` > `jr_en` > `br_taken`.
  - `j_en`: `{pd4[31:28], imm26, 2'b00}`.
  - `jr_en`: `jr_target`.
  - `br_taken`: `pd4 + (br_off << 2)`, 32-bit wrap, with no overflow detection.
  - `redir_live` = OR of the three enables.
- Next-PC selection, highest priority first:
  1. `reset`: `pc <= RESET_PC`, buffer cleared.
  2. `exc_req`: `pc <= EXC_PC`, buffer cleared; this applies even when `f_stall` is high.
  3. `eret_req`: `pc <= epc`, buffer cleared; this applies even when `f_stall` is high.
  4. `f_stall` high: `pc` holds.
     - If `redir_live` and the buffer is empty, capture the live target into the buffer and set it valid.
     - If the buffer is already full, the live redirect is ignored.
  5. Buffer valid: `pc <= buffered target`, buffer cleared; any live redirect in this cycle is ignored.
  6. `redir_live`: `pc <= live target`.
  7. Otherwise `pc <= pc + 4`, with 32-bit wrap.
- `fetch_adel` is a combinational function of the `pc` register:
  - Asserts when `pc[1:0] != 0`, or `pc < IM_BASE`, or `pc >= IM_BASE + 4*IM_WORDS`.
  - Compare the upper bound as a 33-bit value so it cannot wrap.
  - The block does not redirect on AdEL. The exception unit consumes the flag and later raises `exc_req`.
- `redir_pending` mirrors the buffer valid bit.
- State: the 32-bit PC register, the 32-bit buffer target and the buffer valid bit. There is no other FSM.

## Timing
- Reset values: `pc = RESET_PC`, `redir_pending = 0`, `fetch_adel = 0` (requires `RESET_PC` to be inside the IM window).
- All redirects take effect one cycle after assertion: inputs sampled at edge N, new `pc` visible after edge N.
- Buffered redirect: with `f_stall` high in cycle N and a live redirect present, `redir_pending` goes to 1 after edge N. The target is loaded at the first edge where `f_stall` is low.
- `reset` mid-stall or while the buffer is pending: the reset value wins and the buffer is dropped.
- `exc_req` and `eret_req` high in the same cycle: `exc_req` wins.
- `fetch_adel` has zero latency relative to `pc`.

## Test plan
- Reset, then 3 free cycles: `pc` = 0x3000 → 0x3004 → 0x3008 → 0x300C, with `fetch_adel = 0`.
- Branch redirect: `pc_d = 0x3010`, `br_taken = 1`, `br_off = 0xFFFF_FFFE` → next `pc` = 0x300C.
- Jump redirect: `pc_d = 0x3020`, `j_en = 1`, `imm26 = 0x0000C40` → `pc` = 0x0000_3100.
- Simultaneous `jr_en = 1` (`jr_target = 0x3200`) and `br_taken = 1` → `pc` = 0x3200.
- Buffered redirect: `f_stall = 1` with `jr_en = 1` and `jr_target = 0x3400`.
  - `pc` holds and `redir_pending = 1`.
  - A second redirect to 0x3500 during the stall is ignored.
  - On release, `pc` = 0x3400, `redir_pending = 0`, then `pc` = 0x3404.
- Exception and return:
  - `exc_req = 1` while the buffer is pending and `f_stall = 1` → `pc` = 0x4180 and `redir_pending = 0`.
  - `exc_req` and `eret_req` together → `pc` = 0x4180.
  - `eret_req` alone with `epc = 0x3006` → `pc` = 0x3006 and `fetch_adel = 1`.
  - `jr_target = 0x2FFC` → `fetch_adel = 1`.
  - `pc` = `IM_BASE + 4*IM_WORDS` → `fetch_adel = 1`.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program-counter generator.
// Owns the PC register. Picks the next fetch address from reset, exception
// entry, eret return, and j/jr/branch redirects. A one-entry buffer holds a
// redirect that resolves in D while fetch is stalled. The block also flags
// fetch address errors against the instruction-memory window.
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_stall,
  input  logic [31:0] pc_d,
  input  logic        br_taken,
  input  logic [31:0] br_off,
  input  logic        j_en,
  input  logic [25:0] imm26,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic        fetch_adel,
  output logic        redir_pending
);

  // The upper bound is one past the last legal byte. It is held in 33 bits
  // so a window that ends exactly at 4 GiB does not wrap to zero.
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  logic [31:0] pc_reg, pc_next;
  logic [31:0] buf_target_reg, buf_target_next;
  logic        buf_valid_reg, buf_valid_next;

  logic [31:0] pd4;
  logic [31:0] br_target;
  logic [31:0] live_target;
  logic        redir_live;

  assign pd4       = pc_d + 32'd4;
  assign br_target = pd4 + {br_off[29:0], 2'b00};

  // Live redirect target from D. Jumps take priority over jr, and jr over
  // branches.
  always_comb begin
    live_target = br_target;
    if (j_en) begin
      live_target = {pd4[31:28], imm26, 2'b00};
    end else if (jr_en) begin
      live_target = jr_target;
    end
    redir_live = j_en | jr_en | br_taken;
  end

  // Next-state selection. Exception and eret override a stall. A stall holds
  // the PC and may park one redirect. A parked redirect is consumed before
  // any live one.
  always_comb begin
    pc_next         = pc_reg;
    buf_target_next = buf_target_reg;
    buf_valid_next  = buf_valid_reg;
    if (exc_req) begin
      pc_next        = EXC_PC;
      buf_valid_next = 1'b0;
    end else if (eret_req) begin
      pc_next        = epc;
      buf_valid_next = 1'b0;
    end else if (f_stall) begin
      if (redir_live && !buf_valid_reg) begin
        buf_target_next = live_target;
        buf_valid_next  = 1'b1;
      end
    end else if (buf_valid_reg) begin
      pc_next        = buf_target_reg;
      buf_valid_next = 1'b0;
    end else if (redir_live) begin
      pc_next = live_target;
    end else begin
      pc_next = pc_reg + 32'd4;
    end
  end

  // State registers. Reset wins over everything and drops the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg         <= RESET_PC;
      buf_target_reg <= 32'd0;
      buf_valid_reg  <= 1'b0;
    end else begin
      pc_reg         <= pc_next;
      buf_target_reg <= buf_target_next;
      buf_valid_reg  <= buf_valid_next;
    end
  end

  // The address-error flag is a pure function of the current PC. It covers
  // misalignment and addresses outside the window.
  always_comb begin
    fetch_adel = (pc_reg[1:0] != 2'b00) ||
                 (pc_reg < IM_BASE) ||
                 ({1'b0, pc_reg} >= IM_LIMIT);
  end

  assign pc            = pc_reg;
  assign redir_pending = buf_valid_reg;

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen. It runs directed table vectors, hand-written
// multi-cycle sequences, and randomized cycles checked against a reference
// model.
module tb_pc_gen;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_A  = 32'h0000_4180;
  localparam longint      WIN_LO = 64'h3000;
  localparam longint      WIN_HI = 64'h3000 + 4 * 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_stall;
  logic [31:0] pc_d;
  logic        br_taken;
  logic [31:0] br_off;
  logic        j_en;
  logic [25:0] imm26;
  logic        jr_en;
  logic [31:0] jr_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc;
  logic        fetch_adel;
  logic        redir_pending;

  int checks = 0;
  int errors = 0;

  pc_gen dut (
    .clk           (clk),
    .reset         (reset),
    .f_stall       (f_stall),
    .pc_d          (pc_d),
    .br_taken      (br_taken),
    .br_off        (br_off),
    .j_en          (j_en),
    .imm26         (imm26),
    .jr_en         (jr_en),
    .jr_target     (jr_target),
    .exc_req       (exc_req),
    .eret_req      (eret_req),
    .epc           (epc),
    .pc            (pc),
    .fetch_adel    (fetch_adel),
    .redir_pending (redir_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, exc, eret, j, jr, br;
    logic [31:0] pcd;
    logic [25:0] imm;
    logic [31:0] jt, off, ep;
    logic [31:0] exp_pc;
    logic        exp_pend, exp_adel;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic [31:0] e_pc, input logic e_pend,
                           input logic e_adel);
    check({nm, ".pc"}, pc, e_pc);
    check({nm, ".pend"}, {31'd0, redir_pending}, {31'd0, e_pend});
    check({nm, ".adel"}, {31'd0, fetch_adel}, {31'd0, e_adel});
    $display("%s: pc=%h pend=%0b adel=%0b", nm, pc, redir_pending, fetch_adel);
  endtask

  task automatic clear_in();
    f_stall = 0; pc_d = 0; br_taken = 0; br_off = 0; j_en = 0; imm26 = 0;
    jr_en = 0; jr_target = 0; exc_req = 0; eret_req = 0; epc = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic add_vec(input logic st, input logic ex, input logic er, input logic j,
                         input logic jr, input logic br, input logic [31:0] pcd,
                         input logic [25:0] imm, input logic [31:0] jt, input logic [31:0] off,
                         input logic [31:0] ep, input logic [31:0] e_pc, input logic e_pend,
                         input logic e_adel);
    vec_t v;
    v.stall = st; v.exc = ex; v.eret = er; v.j = j; v.jr = jr; v.br = br;
    v.pcd = pcd; v.imm = imm; v.jt = jt; v.off = off; v.ep = ep;
    v.exp_pc = e_pc; v.exp_pend = e_pend; v.exp_adel = e_adel;
    vecs.push_back(v);
  endtask

  // Reference model state. The single-entry buffer is a queue.
  logic [31:0] m_pc;
  logic [31:0] m_buf[$];

  function automatic logic m_adel(input logic [31:0] a);
    longint x;
    x = longint'(a);
    return (a % 4 != 0) || (x < WIN_LO) || (x >= WIN_HI);
  endfunction

  // Applies the next-PC rules to the model state, using the inputs present
  // at the coming edge.
  task automatic model_edge();
    logic [31:0] next4, tgt;
    logic        live;
    next4 = pc_d + 4;
    live  = j_en || jr_en || br_taken;
    if (j_en)       tgt = (next4 & 32'hF000_0000) | (32'(imm26) * 4);
    else if (jr_en) tgt = jr_target;
    else            tgt = next4 + br_off * 4;
    if (reset) begin
      m_pc = RST_PC; m_buf.delete();
    end else if (exc_req) begin
      m_pc = EXC_A; m_buf.delete();
    end else if (eret_req) begin
      m_pc = epc; m_buf.delete();
    end else if (f_stall) begin
      if (live && m_buf.size() == 0) m_buf.push_back(tgt);
    end else if (m_buf.size() != 0) begin
      m_pc = m_buf.pop_front();
    end else if (live) begin
      m_pc = tgt;
    end else begin
      m_pc = m_pc + 4;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'h2F00 + ($urandom % 4300) * 4;
    if ($urandom % 8 == 0) a = a + 2;
    return a;
  endfunction

  initial begin
    logic [15:0] r16;
    reset = 1;
    clear_in();
    step();
    check_all("reset", RST_PC, 1'b0, 1'b0);
    reset = 0;

    // Three free-running cycles after reset.
    step(); check_all("free1", 32'h3004, 1'b0, 1'b0);
    step(); check_all("free2", 32'h3008, 1'b0, 1'b0);
    step(); check_all("free3", 32'h300C, 1'b0, 1'b0);

    // Each directed vector runs for one cycle from a fresh reset (pc=0x3000, buffer empty).
    //       st ex er j  jr br pc_d           imm26         jr_target      br_off         epc            exp_pc         pend adel
    add_vec(0, 0, 0, 0, 0, 0, 32'h0,         26'h0,        32'h0,         32'h0,         32'h0,         32'h3004,      0, 0);
    add_vec(0, 0, 0, 0, 0, 1, 32'h3010,      26'h0,        32'h0,         32'hFFFF_FFFE, 32'h0,         32'h300C,      0, 0);
    add_vec(0, 0, 0, 1, 0, 0, 32'h3020,      26'h0000C40,  32'h0,         32'h0,         32'h0,         32'h3100,      0, 0);
    add_vec(0, 0, 0, 0, 1, 1, 32'h3010,      26'h0,        32'h3200,      32'h10,        32'h0,         32'h3200,      0, 0);
    add_vec(0, 0, 0, 1, 1, 1, 32'h3020,      26'h0000C40,  32'h3200,      32'h10,        32'h0,         32'h3100,      0, 0);
    add_vec(0, 1, 1, 0, 0, 0, 32'h0,         26'h0,        32'h0,         32'h0,         32'h3800,      32'h4180,      0, 0);
    add_vec(0, 0, 1, 0, 1, 0, 32'h0,         26'h0,        32'h3500,      32'h0,         32'h3006,      32'h3006,      0, 1);
    add_vec(0, 0, 0, 0, 1, 0, 32'h0,         26'h0,        32'h2FFC,      32'h0,         32'h0,         32'h2FFC,      0, 1);
    add_vec(0, 0, 0, 0, 1, 0, 32'h0,         26'h0,        32'h7000,      32'h0,         32'h0,         32'h7000,      0, 1);
    add_vec(0, 0, 0, 0, 1, 0, 32'h0,         26'h0,        32'h6FFC,      32'h0,         32'h0,         32'h6FFC,      0, 0);
    add_vec(0, 0, 0, 1, 0, 0, 32'hF000_0000, 26'h3FF_FFFF, 32'h0,         32'h0,         32'h0,         32'hFFFF_FFFC, 0, 1);
    add_vec(1, 0, 0, 0, 1, 0, 32'h0,         26'h0,        32'h3400,      32'h0,         32'h0,         32'h3000,      1, 0);
    add_vec(1, 1, 0, 0, 1, 0, 32'h0,         26'h0,        32'h3400,      32'h0,         32'h0,         32'h4180,      0, 0);
    add_vec(1, 0, 1, 0, 0, 1, 32'h3010,      26'h0,        32'h0,         32'h4,         32'h5000,      32'h5000,      0, 0);

    foreach (vecs[i]) begin
      do_reset();
      f_stall = vecs[i].stall; exc_req = vecs[i].exc; eret_req = vecs[i].eret;
      j_en = vecs[i].j; jr_en = vecs[i].jr; br_taken = vecs[i].br;
      pc_d = vecs[i].pcd; imm26 = vecs[i].imm; jr_target = vecs[i].jt;
      br_off = vecs[i].off; epc = vecs[i].ep;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_pend, vecs[i].exp_adel);
      clear_in();
    end

    // Buffered redirect: capture, a second redirect ignored, consumed on release.
    do_reset();
    f_stall = 1; jr_en = 1; jr_target = 32'h3400;
    step(); check_all("buf_cap", 32'h3000, 1'b1, 1'b0);
    jr_target = 32'h3500;
    step(); check_all("buf_full", 32'h3000, 1'b1, 1'b0);
    f_stall = 0; jr_target = 32'h3600;
    step(); check_all("buf_rel", 32'h3400, 1'b0, 1'b0);
    clear_in();
    step(); check_all("buf_after", 32'h3404, 1'b0, 1'b0);

    // An exception while the buffer is pending and fetch is stalled.
    f_stall = 1; br_taken = 1; pc_d = 32'h3100; br_off = 32'h4;
    step(); check_all("exc_pend0", 32'h3404, 1'b1, 1'b0);
    br_taken = 0; exc_req = 1;
    step(); check_all("exc_pend", EXC_A, 1'b0, 1'b0);
    exc_req = 0; f_stall = 0;
    step(); check_all("exc_after", 32'h4184, 1'b0, 1'b0);

    // Reset in the middle of a pending stall.
    f_stall = 1; j_en = 1; pc_d = 32'h3000; imm26 = 26'hD00;
    step(); check_all("rst_pend0", 32'h4184, 1'b1, 1'b0);
    reset = 1;
    step(); check_all("rst_pend", RST_PC, 1'b0, 1'b0);
    reset = 0; clear_in();
    step(); check_all("rst_after", 32'h3004, 1'b0, 1'b0);

    // The sequential +4 wraps at the top of the address space.
    eret_req = 1; epc = 32'hFFFF_FFFC;
    step(); check_all("wrap0", 32'hFFFF_FFFC, 1'b0, 1'b1);
    clear_in();
    step(); check_all("wrap1", 32'h0, 1'b0, 1'b1);

    // Randomized cycles against the reference model.
    do_reset();
    m_pc = RST_PC;
    m_buf.delete();
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom % 100 == 0);
      f_stall   = ($urandom % 4 == 0);
      br_taken  = ($urandom % 5 == 0);
      j_en      = ($urandom % 8 == 0);
      jr_en     = ($urandom % 8 == 0);
      exc_req   = ($urandom % 40 == 0);
      eret_req  = ($urandom % 30 == 0);
      pc_d      = 32'h3000 + ($urandom % 4096) * 4;
      r16       = 16'($urandom);
      br_off    = {{16{r16[15]}}, r16};
      imm26     = 26'($urandom);
      jr_target = rand_addr();
      epc       = rand_addr();
      model_edge();
      step();
      check($sformatf("rnd%0d.pc", n), pc, m_pc);
      check($sformatf("rnd%0d.pend", n), {31'd0, redir_pending}, {31'd0, m_buf.size() != 0});
      check($sformatf("rnd%0d.adel", n), {31'd0, fetch_adel}, {31'd0, m_adel(m_pc)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
